// File: rtl/pixel_word_packer.sv
// pixel_word_packer: gathers PIXELWIDTH-bit pixels LSB-first into 64-bit host
// words. A pixel marked in_last flushes a partially filled word, zero-padded,
// with a byte-keep mask covering the filled lanes and out_last set.
module pixel_word_packer #(
  parameter int BITS = 5                  // log2 of pixel width, legal 3..6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [(1<<BITS)-1:0]   in_data,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [63:0]            out_data,
  output logic [7:0]             out_keep,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int W  = 1 << BITS;          // pixel width in bits
  localparam int N  = 64 >> BITS;         // pixels per host word
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int KB = W / 8;              // keep bits per lane

  localparam logic [CW-1:0] LAST_LANE = CW'(N - 1);

  logic [63:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   data_q, data_d;
  logic [7:0]    keep_q, keep_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;

  logic          accept;
  logic          complete;
  logic [5:0]    lane_base;
  logic [3:0]    keep_bytes;
  logic [7:0]    keep_mask;
  logic [63:0]   merged;

  // Input is accepted whenever the output register is empty or draining now.
  assign in_ready = !rst && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = (cnt_q == LAST_LANE) || in_last;

  // Current pixel merged into the accumulator at lane cnt, plus its keep mask.
  always_comb begin
    lane_base  = 6'(int'(cnt_q) * W);
    keep_bytes = 4'((int'(cnt_q) + 1) * KB);
    keep_mask  = 8'((16'd1 << keep_bytes) - 16'd1);
    merged     = acc_q;
    merged[lane_base +: W] = in_data;
  end

  // Next-state for accumulator, lane count and output register.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      if (complete) begin
        // Lanes above cnt are already zero because acc is cleared per word.
        data_d  = merged;
        keep_d  = keep_mask;
        last_d  = in_last;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d   = merged;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any partial word and any pending output.
  // NOTE: sequential state uses non-blocking assignments only, and the
  // accumulator is a plain register (not a memory), so it is reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

endmodule
